// File: rtl/rip_branch_predictor_table_pkg.sv
// Shared types and counter helpers for the branch direction predictor table.
// Counter helpers operate on up to 4-bit counters; callers cast to their own width.
package rip_branch_predictor_table_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } bp_state_t;

    localparam int MAX_CTR_W = 4;

    function automatic logic [MAX_CTR_W-1:0] weak_nt(input int width);
        return MAX_CTR_W'((1 << (width - 1)) - 1);
    endfunction

    // Saturating step: never wraps past all-ones or below zero.
    function automatic logic [MAX_CTR_W-1:0] sat_next(input logic [MAX_CTR_W-1:0] ctr,
                                                      input logic                 taken,
                                                      input int                   width);
        logic [MAX_CTR_W-1:0] max_v;
        max_v = MAX_CTR_W'((1 << width) - 1);
        if (taken)
            return (ctr >= max_v) ? max_v : ctr + 1'b1;
        else
            return (ctr == '0) ? '0 : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/rip_bp_sat_counter.sv
// Combinational saturating next-state for one COUNTER_WIDTH counter.
// Zero latency; no flow control.
module rip_bp_sat_counter
    import rip_branch_predictor_table_pkg::*;
#(
    parameter int COUNTER_WIDTH = 2
) (
    input  logic [COUNTER_WIDTH-1:0] ctr,
    input  logic                     taken,
    output logic [COUNTER_WIDTH-1:0] ctr_next
);

    logic [MAX_CTR_W-1:0] ctr_ext;
    logic [MAX_CTR_W-1:0] next_ext;

    assign ctr_ext  = MAX_CTR_W'(ctr);
    assign next_ext = sat_next(ctr_ext, taken, COUNTER_WIDTH);
    assign ctr_next = COUNTER_WIDTH'(next_ext);

endmodule

// File: rtl/rip_branch_predictor_table.sv
// Saturating-counter direction predictor (bimodal or gshare); prediction one cycle after lookup.
// Lookups stalled (lookup_ready=0) during the post-reset table sweep; optional BP_STATS_EN counters.
module rip_branch_predictor_table
    import rip_branch_predictor_table_pkg::*;
#(
    parameter int PC_WIDTH      = 32,
    parameter int PC_LSB        = 2,
    parameter int INDEX_WIDTH   = 10,
    parameter int COUNTER_WIDTH = 2,
    parameter int HISTORY_LEN   = 10,
    parameter int GSHARE        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_done,
    input  logic                   lookup_valid,
    output logic                   lookup_ready,
    input  logic [PC_WIDTH-1:0]    lookup_pc,
    output logic                   pred_valid,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic                   upd_taken,
    input  logic                   upd_mispred
`ifdef BP_STATS_EN
    ,
    output logic [31:0]            stat_lookups,
    output logic [31:0]            stat_updates,
    output logic [31:0]            stat_mispredicts
`endif
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [COUNTER_WIDTH-1:0] WEAK_NT = COUNTER_WIDTH'(weak_nt(COUNTER_WIDTH));

    bp_state_t                state_q, state_d;
    logic                     sweep_we;
    logic [INDEX_WIDTH-1:0]   ptr_q;
    logic [HISTORY_LEN-1:0]   ghr_q, ghr_next;
    logic [COUNTER_WIDTH-1:0] table_q [DEPTH];

    logic                     u1_vld_q;
    logic [INDEX_WIDTH-1:0]   u1_idx_q;
    logic                     u1_taken_q;
    logic [COUNTER_WIDTH-1:0] u1_next;

    logic                     lookup_fire, upd_fire;
    logic [INDEX_WIDTH-1:0]   base_index, lookup_index;

    assign lookup_ready = init_done;
    assign lookup_fire  = lookup_valid && lookup_ready;
    assign upd_fire     = upd_valid && init_done;

    assign base_index   = lookup_pc[PC_LSB +: INDEX_WIDTH];
    assign lookup_index = (GSHARE != 0) ? (base_index ^ INDEX_WIDTH'(ghr_q)) : base_index;

    always_ff @(posedge clk) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (ptr_q == '1) state_d = READY;
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        init_done = (state_q == READY);
        sweep_we  = (state_q == INIT);
    end

    always_ff @(posedge clk) begin
        if (rst)           ptr_q <= '0;
        else if (sweep_we) ptr_q <= ptr_q + 1'b1;
    end

    generate
        if (HISTORY_LEN == 1) begin : g_ghr1
            assign ghr_next = upd_taken;
        end else begin : g_ghrn
            assign ghr_next = {ghr_q[HISTORY_LEN-2:0], upd_taken};
        end
    endgenerate

    // U0: capture the training request and shift the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q      <= '0;
            u1_vld_q   <= 1'b0;
            u1_idx_q   <= '0;
            u1_taken_q <= 1'b0;
        end else begin
            u1_vld_q <= upd_fire;
            if (upd_fire) begin
                ghr_q      <= ghr_next;
                u1_idx_q   <= upd_index;
                u1_taken_q <= upd_taken;
            end
        end
    end

    rip_bp_sat_counter #(
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_sat (
        .ctr      (table_q[u1_idx_q]),
        .taken    (u1_taken_q),
        .ctr_next (u1_next)
    );

    // U1 write shares the single port with the sweep; a reset edge blocks both.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_we)      table_q[ptr_q]    <= WEAK_NT;
            else if (u1_vld_q) table_q[u1_idx_q] <= u1_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_index <= '0;
        end else begin
            pred_valid <= lookup_fire;
            if (lookup_fire) begin
                pred_taken <= table_q[lookup_index][COUNTER_WIDTH-1];
                pred_index <= lookup_index;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups     <= '0;
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (lookup_fire && stat_lookups != '1)
                stat_lookups <= stat_lookups + 1'b1;
            if (upd_fire && stat_updates != '1)
                stat_updates <= stat_updates + 1'b1;
            if (upd_fire && upd_mispred && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`else
    logic unused_mispred;
    assign unused_mispred = upd_mispred;
`endif

endmodule

// File: doc/rip_branch_predictor_table.md
Name: rip_branch_predictor_table

Overview:
- Parametrised direction predictor: table of N-bit saturating counters, indexed bimodally or gshare-style by a global history register (GHR).
- Sits in fetch: lookup on the fetch PC, registered prediction next cycle; trains from commit with resolved outcomes.
- Clears its table after reset with a sweep FSM.
- Generalises the fixed 2-bit bimodal/gshare scheme to configurable counter width, index width, history length and run-time-fixed mode.

Parameters:
- PC_WIDTH, 32, width of lookup_pc.
- PC_LSB, 2, lowest PC bit used for indexing.
- INDEX_WIDTH, 10, log2 of table depth; table has 2**INDEX_WIDTH entries.
- COUNTER_WIDTH, 2, saturating-counter width; legal range 1..4.
- HISTORY_LEN, 10, GHR length; legal range 1..INDEX_WIDTH.
- GSHARE, 1, 0 = bimodal index, 1 = gshare index.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_done  out  1  table sweep complete
- lookup_valid  in  1  lookup request
- lookup_ready  out  1  lookup accepted when high (equals init_done)
- lookup_pc  in  PC_WIDTH  fetch PC
- pred_valid  out  1  prediction valid
- pred_taken  out  1  predicted direction
- pred_index  out  INDEX_WIDTH  index used; carried down the pipe and returned on update
- upd_valid  in  1  commit-time training request
- upd_index  in  INDEX_WIDTH  index from the original prediction
- upd_taken  in  1  resolved direction
- upd_mispred  in  1  resolved direction differed from prediction (statistics only)

Behaviour:
- Reset values: init_done=0, lookup_ready=0, pred_valid=0, pred_taken=0, pred_index=0, GHR=0, sweep pointer=0, state=INIT.
- Index: base = lookup_pc[PC_LSB +: INDEX_WIDTH].
  - GSHARE=1: index = base XOR zero-extended GHR.
  - GSHARE=0: index = base; the GHR is still maintained.
- FSM INIT:
  - Each cycle writes WEAK_NT = 2**(COUNTER_WIDTH-1)-1 to entry[ptr] and increments ptr.
  - When ptr = all-ones is written, moves to READY next cycle.
  - Sweep takes exactly 2**INDEX_WIDTH cycles after rst deasserts.
  - Lookups and updates are ignored; pred_valid stays 0.
- FSM READY: init_done=1; stays in READY until rst.
- rst asserted in any state (mid-sweep, mid-update) returns to INIT with ptr=0 and discards any in-flight update.
- Lookup:
  - Accepted at edge t when lookup_valid && lookup_ready.
  - At t+1: pred_valid=1, pred_taken = counter MSB, pred_index = index computed with the GHR value present at t.
  - pred_valid is 0 in any cycle not following an accepted lookup.
  - No backpressure on the prediction side.
- Update pipeline, 2 stages:
  - U0, edge t: capture upd_index/upd_taken into stage register; GHR <= {GHR[HISTORY_LEN-2:0], upd_taken}. For HISTORY_LEN=1, GHR <= upd_taken.
  - U1, cycle t+1: read entry, compute saturating next value, write at edge t+1.
- Saturation:
  - taken: increment unless all-ones.
  - not taken: decrement unless zero.
  - Counter arithmetic is COUNTER_WIDTH bits with no wrap.
- Visibility:
  - A lookup accepted at edge t+2 or later sees the trained counter.
  - A lookup accepted at t or t+1 sees the old value; the table read is read-before-write.
  - A lookup accepted at edge t+1 uses the updated GHR.
- Back-to-back updates to the same index on consecutive cycles each apply once, in order, with no loss. U1 reads the array after the previous write, so no forwarding path is needed.
- Updates arriving during INIT are dropped and do not change the GHR.
- Simultaneous lookup and update in the same cycle are both accepted.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds outputs stat_lookups, stat_updates, stat_mispredicts, each 32 bits:
  - count accepted lookups, updates, and updates with upd_mispred=1;
  - saturate at 32'hFFFF_FFFF;
  - cleared by rst;
  - do not count during INIT.
- When undefined, these ports and their counters do not exist, and upd_mispred is unused.

Decomposition:
- Package rip_branch_predictor_table_pkg holds:
  - typedef bp_state_t {INIT, READY};
  - function weak_nt(width);
  - function sat_next(ctr, taken, width).
- One sub-module, rip_bp_sat_counter: combinational saturating next-state for a COUNTER_WIDTH counter, instantiated in U1.

Test Plan:
- Reset then idle, INDEX_WIDTH=4: init_done rises exactly 16 cycles after rst falls. Lookups at all 16 PCs return pred_taken=0, with every entry =1 (COUNTER_WIDTH=2).
- Bimodal, COUNTER_WIDTH=2, pc=0x40 (index 0 for INDEX_WIDTH=4):
  - 2 taken updates give counter 1→2→3; lookup ≥2 cycles later gives pred_taken=1.
  - A 3rd taken update keeps it at 3.
  - 4 not-taken updates reach 0 and hold.
- GSHARE=1, INDEX_WIDTH=4, HISTORY_LEN=4: updates taken,taken,not-taken give GHR=4'b0110. A lookup at pc=0x0 then returns pred_index=6.
- Same-index update at t and lookup at t+1 returns the old value. Lookup at t+2 returns the new value. Consecutive updates to index 3 at t,t+1 both apply.
- rst pulsed at sweep ptr=7: init_done=0, the sweep restarts at 0, GHR=0, the pending update is discarded, and init_done rises 16 cycles later.
- BP_STATS_EN: 5 lookups plus 3 updates (1 mispredict) give stat_lookups=5, stat_updates=3, stat_mispredicts=1. A forced 32'hFFFF_FFFF value stays saturated.
